// File: rtl/multicycle_controller.sv
// Control unit for the multi-cycle RV32I core: main FSM, ALU decoder,
// memory-ready handshake and retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           Op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUControl,
  output logic                 illegal_op,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  state_t      state, state_next;
  logic [1:0]  alu_op;
  logic        pc_write, mem_write, ir_write, reg_write, illegal;
  logic        retire;

  // State register; reset parks the FSM in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state and Moore/Mealy control outputs
  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    alu_op     = 2'b00;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_IALU:      state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = Op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b01;
        pc_write   = Zero;
        state_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Strobes are held low for as long as reset is asserted
  assign PCWrite    = pc_write  & rst_n;
  assign MemWrite   = mem_write & rst_n;
  assign IRWrite    = ir_write  & rst_n;
  assign RegWrite   = reg_write & rst_n;
  assign illegal_op = illegal   & rst_n;

  // Immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = 2'b00;
    case (Op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (Op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // An instruction retires on the final cycle of its writeback/commit state
  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  ((state == S_MEMWRITE) && mem_ready);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + INSTRET_W'(1);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IALU = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] LUI  = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic        funct7b5, Zero, mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret;
  logic [14:0] outs;

  int total = 0;
  int bad   = 0;

  multicycle_controller #(.INSTRET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal_op(illegal_op), .instret(instret)
  );

  always #5 clk = ~clk;

  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, illegal_op};

  // Pack an expected control word in the same field order as outs
  function automatic logic [14:0] v(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic rw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [2:0] alc, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alc, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, apply inputs, let comb logic settle, check controls
  task automatic cyc(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input logic mr, input logic [14:0] exp);
    @(posedge clk);
    #1;
    Op = op; funct3 = f3; funct7b5 = f7; Zero = z; mem_ready = mr;
    #1;
    chk(tag, 32'(outs), 32'(exp));
  endtask

  logic [14:0] v_fetch, v_fetch_wait, v_dec, v_madr, v_mrd, v_mwb, v_mwr, v_awb, v_rst;

  initial begin
    v_fetch      = v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0);
    v_fetch_wait = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0);
    v_rst        = v_fetch_wait;
    v_dec        = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0);
    v_madr       = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0);
    v_mrd        = v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    v_mwb        = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0);
    v_mwr        = v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    v_awb        = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);

    // Reset with mem_ready high: IRWrite/PCWrite must still be low
    rst_n = 1'b0; Op = LW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("reset_ctrl", 32'(outs), 32'(v_rst));
    chk("reset_instret", instret, 32'd0);

    // lw, mem_ready=1: 5 cycles
    @(posedge clk); #1; rst_n = 1'b1; #1;
    chk("lw_fetch", 32'(outs), 32'(v_fetch));
    cyc("lw_decode",  LW, 3'b010, 1'b0, 1'b0, 1'b1, v_dec);
    chk("lw_imm", 32'(ImmSrc), 32'd0);
    cyc("lw_memadr",  LW, 3'b010, 1'b0, 1'b0, 1'b1, v_madr);
    cyc("lw_memread", LW, 3'b010, 1'b0, 1'b0, 1'b1, v_mrd);
    cyc("lw_memwb",   LW, 3'b010, 1'b0, 1'b0, 1'b1, v_mwb);
    chk("lw_instret_before", instret, 32'd0);

    // sw with three wait cycles in MEMWRITE
    cyc("sw_fetch",   SW, 3'b010, 1'b0, 1'b0, 1'b1, v_fetch);
    chk("lw_instret_after", instret, 32'd1);
    cyc("sw_decode",  SW, 3'b010, 1'b0, 1'b0, 1'b1, v_dec);
    chk("sw_imm", 32'(ImmSrc), 32'd1);
    cyc("sw_memadr",  SW, 3'b010, 1'b0, 1'b0, 1'b1, v_madr);
    cyc("sw_wait1",   SW, 3'b010, 1'b0, 1'b0, 1'b0, v_mwr);
    cyc("sw_wait2",   SW, 3'b010, 1'b0, 1'b0, 1'b0, v_mwr);
    chk("sw_instret_wait", instret, 32'd1);
    cyc("sw_wait3",   SW, 3'b010, 1'b0, 1'b0, 1'b0, v_mwr);
    cyc("sw_done",    SW, 3'b010, 1'b0, 1'b0, 1'b1, v_mwr);
    chk("sw_instret_done_cycle", instret, 32'd1);

    // add
    cyc("add_fetch",  RT, 3'b000, 1'b0, 1'b0, 1'b1, v_fetch);
    chk("sw_instret_after", instret, 32'd2);
    cyc("add_decode", RT, 3'b000, 1'b0, 1'b0, 1'b1, v_dec);
    cyc("add_exec",   RT, 3'b000, 1'b0, 1'b0, 1'b1,
        v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0));
    cyc("add_wb",     RT, 3'b000, 1'b0, 1'b0, 1'b1, v_awb);

    // sub
    cyc("sub_fetch",  RT, 3'b000, 1'b1, 1'b0, 1'b1, v_fetch);
    cyc("sub_decode", RT, 3'b000, 1'b1, 1'b0, 1'b1, v_dec);
    cyc("sub_exec",   RT, 3'b000, 1'b1, 1'b0, 1'b1,
        v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0));
    cyc("sub_wb",     RT, 3'b000, 1'b1, 1'b0, 1'b1, v_awb);

    // addi with funct7b5=1 stays add
    cyc("addi_fetch",  IALU, 3'b000, 1'b1, 1'b0, 1'b1, v_fetch);
    cyc("addi_decode", IALU, 3'b000, 1'b1, 1'b0, 1'b1, v_dec);
    cyc("addi_exec",   IALU, 3'b000, 1'b1, 1'b0, 1'b1,
        v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0));
    cyc("addi_wb",     IALU, 3'b000, 1'b1, 1'b0, 1'b1, v_awb);

    // ori and slti through the I-type path
    cyc("ori_fetch",  IALU, 3'b110, 1'b0, 1'b0, 1'b1, v_fetch);
    cyc("ori_decode", IALU, 3'b110, 1'b0, 1'b0, 1'b1, v_dec);
    cyc("ori_exec",   IALU, 3'b110, 1'b0, 1'b0, 1'b1,
        v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b011, 1'b0));
    cyc("ori_wb",     IALU, 3'b110, 1'b0, 1'b0, 1'b1, v_awb);
    cyc("slti_fetch",  IALU, 3'b010, 1'b0, 1'b0, 1'b1, v_fetch);
    chk("ori_instret", instret, 32'd6);
    cyc("slti_decode", IALU, 3'b010, 1'b0, 1'b0, 1'b1, v_dec);
    cyc("slti_exec",   IALU, 3'b010, 1'b0, 1'b0, 1'b1,
        v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b101, 1'b0));
    cyc("slti_wb",     IALU, 3'b010, 1'b0, 1'b0, 1'b1, v_awb);

    // beq taken then not taken, 3 cycles each
    cyc("beq1_fetch",  BEQ, 3'b000, 1'b0, 1'b1, 1'b1, v_fetch);
    cyc("beq1_decode", BEQ, 3'b000, 1'b0, 1'b1, 1'b1, v_dec);
    chk("beq_imm", 32'(ImmSrc), 32'd2);
    cyc("beq1_exec",   BEQ, 3'b000, 1'b0, 1'b1, 1'b1,
        v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0));
    cyc("beq0_fetch",  BEQ, 3'b000, 1'b0, 1'b0, 1'b1, v_fetch);
    chk("beq1_instret", instret, 32'd8);
    cyc("beq0_decode", BEQ, 3'b000, 1'b0, 1'b0, 1'b1, v_dec);
    cyc("beq0_exec",   BEQ, 3'b000, 1'b0, 1'b0, 1'b1,
        v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0));

    // jal
    cyc("jal_fetch",  JAL, 3'b000, 1'b0, 1'b0, 1'b1, v_fetch);
    chk("beq0_instret", instret, 32'd9);
    cyc("jal_decode", JAL, 3'b000, 1'b0, 1'b0, 1'b1, v_dec);
    chk("jal_imm", 32'(ImmSrc), 32'd3);
    cyc("jal_jal",    JAL, 3'b000, 1'b0, 1'b0, 1'b1,
        v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0));
    cyc("jal_wb",     JAL, 3'b000, 1'b0, 1'b0, 1'b1, v_awb);

    // Unsupported opcode after one FETCH wait cycle
    cyc("ill_fetch_wait", LUI, 3'b000, 1'b0, 1'b0, 1'b0, v_fetch_wait);
    chk("jal_instret", instret, 32'd10);
    cyc("ill_fetch",  LUI, 3'b000, 1'b0, 1'b0, 1'b1, v_fetch);
    cyc("ill_decode", LUI, 3'b000, 1'b0, 1'b0, 1'b1,
        v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b1));
    cyc("ill_refetch", LW, 3'b010, 1'b0, 1'b0, 1'b1, v_fetch);
    chk("ill_instret", instret, 32'd10);

    // Reset asserted during a MEMREAD wait
    cyc("rst_lw_decode",  LW, 3'b010, 1'b0, 1'b0, 1'b1, v_dec);
    cyc("rst_lw_memadr",  LW, 3'b010, 1'b0, 1'b0, 1'b1, v_madr);
    cyc("rst_lw_wait",    LW, 3'b010, 1'b0, 1'b0, 1'b0, v_mrd);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 32'(outs), 32'(v_rst));
    chk("rst_mid_instret", instret, 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1;
    chk("rst_hold_ctrl", 32'(outs), 32'(v_rst));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_release_fetch", 32'(outs), 32'(v_fetch));
    chk("rst_release_instret", instret, 32'd0);
    cyc("rst_release_decode", LW, 3'b010, 1'b0, 1'b0, 1'b1, v_dec);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multi-cycle RV32I core. It sequences the shared datapath (one ALU, one unified instruction/data memory port, the PC and IR registers) through fetch, decode, execute, memory and writeback cycles. It supports lw, sw, R-type, I-type ALU, beq and jal. The block contains the main FSM, the ALU decoder, a memory-ready handshake and a retired-instruction counter.

## Interface
- INSTRET_W, 32, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU zero flag, from the current cycle's ALU result
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC load strobe
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR/OldPC load strobe
- RegWrite  out  1  register file write strobe
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J; decoded combinationally from Op in every state
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- instret  out  INSTRET_W  count of retired instructions

## Operation
- Opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
- States and Moore outputs. Unlisted selects are 00/0; unlisted strobes are 0.
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. If mem_ready=1, go to DECODE; otherwise hold.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
    - lw/sw → MEMADR
    - R → EXECUTER
    - I-ALU → EXECUTEI
    - beq → BEQ
    - jal → JAL
    - any other opcode → FETCH, with illegal_op=1 this cycle
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready=1, then → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1, held high throughout the wait. Hold until mem_ready=1, then → FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero → FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 → ALUWB.
- ALU decoder (ALUOp is internal):
  - ALUOp 00 → add
  - ALUOp 01 → sub
  - ALUOp 10, by funct3:
    - 000 → sub if Op[5]&funct7b5, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - other → add
- instret increments by 1 on the cycle an instruction retires, i.e. the last cycle of MEMWB, ALUWB, BEQ, or MEMWRITE with mem_ready=1. It wraps from 2^INSTRET_W−1 to 0. An illegal opcode does not retire.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=FETCH, instret=0, illegal_op=0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 combinationally while rst_n=0.
  - Selects take their FETCH values.
- First fetch starts on the first rising edge after rst_n deasserts.
- Cycle counts with mem_ready tied to 1:
  - lw 5
  - sw 4
  - R/I 4
  - beq 3
  - jal 4
  - illegal 2
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. All outputs stay stable during the wait.
- Strobes are combinational from state, plus mem_ready or Zero where noted. There is no registered output latency.
- Reset asserted mid-instruction (including mid-MEMWRITE wait): state goes to FETCH immediately and strobes drop in the same cycle. The partial instruction is not counted.

## Test plan
- lw, mem_ready=1: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 with ResultSrc=01 only in cycle 5; instret 0→1.
- sw, mem_ready low for 3 cycles in MEMWRITE: MemWrite=1 for 4 consecutive cycles with AdrSrc=1; instret increments only on the mem_ready=1 cycle.
- add, then sub (funct7b5=1), then addi with funct7b5=1: ALUControl=000, 001, 000 respectively in the execute cycle.
- beq with Zero=1 → PCWrite=1 in BEQ. Same instruction with Zero=0 → PCWrite=0. Both take 3 cycles and retire.
- jal: JAL cycle has PCWrite=1, ALUSrcA=01, ALUSrcB=10. The ALUWB cycle has RegWrite=1.
- Op=0110111 (unsupported): illegal_op pulses in the DECODE cycle and FETCH follows. instret is unchanged.
- rst_n pulled low during MEMREAD wait: strobes 0 at once. After release, FETCH with instret=0.
